dmem_arbiter: RTL and testbench

Round-robin arbiter sharing the single-port data memory of the multi-core processor between `NUM_CORES` processing cores. It accepts one read or write request per core, serialises them onto the memory port, and returns read data with a one-cycle acknowledge to the winning core. It sits between the core array and the shared data memory, under the top-level `main` controller. The controller gates new grants through `enable`, so that the load and dump phases own the memory exclusively.

---
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter serialising per-core read/write requests onto one single-port data memory.
// Latency: mem_en one cycle after the request is sampled, ack two cycles later; 4 cycles per access.
// Backpressure: requests are held until ack; enable low blocks new grants without aborting one in flight.
module dmem_arbiter #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_CORES-1:0]        core_req,
    input  logic [NUM_CORES-1:0]        core_we,
    input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
    input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
    output logic [NUM_CORES-1:0]        core_grant,
    output logic [NUM_CORES-1:0]        core_ack,
    output logic [DATA_W-1:0]           core_rdata,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic                        busy,
    output logic [15:0]                 xfer_count
);
    localparam int PTR_W = $clog2(NUM_CORES);
    localparam logic [PTR_W:0]   NC   = (PTR_W+1)'(NUM_CORES);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_CORES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

    state_t           state, state_nxt;
    logic [PTR_W-1:0] ptr, win, pick;
    logic             pick_vld;
    logic             win_we;
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    logic [ADDR_W-1:0] addr_arr  [NUM_CORES];
    logic [DATA_W-1:0] wdata_arr [NUM_CORES];

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_unpack
        assign addr_arr[g]  = core_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = core_wdata[g*DATA_W +: DATA_W];
    end

    // First requester at or above ptr, wrapping modulo NUM_CORES (not a power of two in general).
    always_comb begin
        pick     = ptr;
        pick_vld = 1'b0;
        sum      = '0;
        idx      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (sum >= NC)
                sum = sum - NC;
            idx = sum[PTR_W-1:0];
            if (!pick_vld && core_req[idx]) begin
                pick_vld = 1'b1;
                pick     = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            win        <= '0;
            win_we     <= 1'b0;
            core_grant <= '0;
            core_ack   <= '0;
            core_rdata <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            xfer_count <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (enable && pick_vld) begin
                        win        <= pick;
                        win_we     <= core_we[pick];
                        mem_en     <= 1'b1;
                        mem_we     <= core_we[pick];
                        mem_addr   <= addr_arr[pick];
                        mem_wdata  <= wdata_arr[pick];
                        core_grant <= NUM_CORES'(1) << pick;
                        busy       <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                end
                WAIT: begin
                    core_ack <= core_grant;
                    if (!win_we)
                        core_rdata <= mem_rdata;
                    ptr <= (win == LAST) ? '0 : win + 1'b1;
                    if (xfer_count != 16'hFFFF)
                        xfer_count <= xfer_count + 16'd1;
                end
                ACK: begin
                    core_ack   <= '0;
                    core_grant <= '0;
                    busy       <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous 256x16 memory model on the memory port.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  core_req;
    logic [3:0]  core_we;
    logic [31:0] core_addr;
    logic [63:0] core_wdata;
    logic [3:0]  core_grant;
    logic [3:0]  core_ack;
    logic [15:0] core_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;
    logic [15:0] xfer_count;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [256];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    dmem_arbiter #(.NUM_CORES(4), .ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_grant(core_grant), .core_ack(core_ack), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy), .xfer_count(xfer_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int i, input logic req, input logic we,
                            input logic [7:0] a, input logic [15:0] d);
        core_req[i]          = req;
        core_we[i]           = we;
        core_addr[i*8 +: 8]  = a;
        core_wdata[i*16 +: 16] = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_grant"}, 32'(core_grant), 32'h0);
        check({tag, "_ack"},   32'(core_ack),   32'h0);
        check({tag, "_rdata"}, 32'(core_rdata), 32'h0);
        check({tag, "_mem_en"},32'(mem_en),     32'h0);
        check({tag, "_mem_we"},32'(mem_we),     32'h0);
        check({tag, "_addr"},  32'(mem_addr),   32'h0);
        check({tag, "_wdata"}, 32'(mem_wdata),  32'h0);
        check({tag, "_busy"},  32'(busy),       32'h0);
        check({tag, "_xfer"},  32'(xfer_count), 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
        mem[8'h10] = 16'h00AB;
        rst = 1'b1; enable = 1'b1;
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        tick(); tick();
        check_reset_state("rst");
        rst = 1'b0;

        // Single read by core 2
        set_core(2, 1'b1, 1'b0, 8'h10, 16'h0);
        tick();
        check("rd_mem_en", 32'(mem_en), 32'h1);
        check("rd_mem_we", 32'(mem_we), 32'h0);
        check("rd_addr",   32'(mem_addr), 32'h10);
        check("rd_grant",  32'(core_grant), 32'h4);
        check("rd_busy",   32'(busy), 32'h1);
        tick();
        check("rd_wait_en",  32'(mem_en), 32'h0);
        check("rd_wait_ack", 32'(core_ack), 32'h0);
        tick();
        check("rd_ack",   32'(core_ack), 32'h4);
        check("rd_rdata", 32'(core_rdata), 32'h00AB);
        check("rd_xfer",  32'(xfer_count), 32'h1);
        set_core(2, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();
        check("rd_idle_ack",   32'(core_ack), 32'h0);
        check("rd_idle_grant", 32'(core_grant), 32'h0);
        check("rd_idle_busy",  32'(busy), 32'h0);

        // Write 1234 to 05 by core 0, then read it back
        set_core(0, 1'b1, 1'b1, 8'h05, 16'h1234);
        tick();
        check("wr_mem_we", 32'(mem_we), 32'h1);
        check("wr_wdata",  32'(mem_wdata), 32'h1234);
        check("wr_grant",  32'(core_grant), 32'h1);
        tick();
        check("wr_wait_we",   32'(mem_we), 32'h0);
        check("wr_wait_addr", 32'(mem_addr), 32'h05);
        tick();
        check("wr_ack",       32'(core_ack), 32'h1);
        check("wr_rdata_keep",32'(core_rdata), 32'h00AB);
        set_core(0, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();
        set_core(0, 1'b1, 1'b0, 8'h05, 16'h0);
        tick();
        check("rb_mem_we", 32'(mem_we), 32'h0);
        tick(); tick();
        check("rb_ack",   32'(core_ack), 32'h1);
        check("rb_rdata", 32'(core_rdata), 32'h1234);
        check("rb_xfer",  32'(xfer_count), 32'h3);
        set_core(0, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();

        // Pointer skip: ptr=1, cores 0 and 3 request -> 3 first, then 0
        set_core(0, 1'b1, 1'b0, 8'h01, 16'h0);
        set_core(3, 1'b1, 1'b0, 8'h02, 16'h0);
        tick();
        check("skip_grant3", 32'(core_grant), 32'h8);
        tick(); tick();
        check("skip_ack3", 32'(core_ack), 32'h8);
        set_core(3, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();
        check("skip_idle", 32'(core_grant), 32'h0);
        tick();
        check("skip_grant0", 32'(core_grant), 32'h1);
        tick(); tick();
        check("skip_ack0", 32'(core_ack), 32'h1);
        set_core(0, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();

        // Enable gating: core 1 granted, enable drops in WAIT, core 2 pending
        set_core(1, 1'b1, 1'b0, 8'h03, 16'h0);
        set_core(2, 1'b1, 1'b0, 8'h04, 16'h0);
        tick();
        check("en_grant1", 32'(core_grant), 32'h2);
        tick();
        enable = 1'b0;
        tick();
        check("en_ack1", 32'(core_ack), 32'h2);
        set_core(1, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();
        tick();
        check("en_blocked_grant", 32'(core_grant), 32'h0);
        check("en_blocked_en",    32'(mem_en), 32'h0);
        tick();
        check("en_blocked_busy",  32'(busy), 32'h0);
        enable = 1'b1;
        tick();
        check("en_grant2", 32'(core_grant), 32'h4);
        tick(); tick();
        check("en_ack2",  32'(core_ack), 32'h4);
        check("en_xfer",  32'(xfer_count), 32'h7);
        set_core(2, 1'b0, 1'b0, 8'h0, 16'h0);
        tick();

        // Round robin from reset with all cores requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rr_rst_xfer", 32'(xfer_count), 32'h0);
        for (int i = 0; i < 4; i++) set_core(i, 1'b1, 1'b0, 8'(8'h20 + i), 16'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rr%0d_grant", k), 32'(core_grant), 32'(4'b1 << (k % 4)));
            check($sformatf("rr%0d_ack_pre", k), 32'(core_ack), 32'h0);
            tick(); tick();
            check($sformatf("rr%0d_ack", k), 32'(core_ack), 32'(4'b1 << (k % 4)));
            tick();
            check($sformatf("rr%0d_ack_post", k), 32'(core_ack), 32'h0);
        end
        check("rr_xfer", 32'(xfer_count), 32'h5);

        // Reset mid-write: ptr=1, cores 0 and 3 write -> 3 granted, reset in ISSUE
        core_req = '0;
        set_core(0, 1'b1, 1'b1, 8'h40, 16'h5555);
        set_core(3, 1'b1, 1'b1, 8'h41, 16'h6666);
        tick();
        check("mr_grant3", 32'(core_grant), 32'h8);
        check("mr_mem_we", 32'(mem_we), 32'h1);
        rst = 1'b1;
        tick();
        check_reset_state("mr");
        rst = 1'b0;
        tick();
        check("mr_grant_low", 32'(core_grant), 32'h1);
        check("mr_addr_low",  32'(mem_addr), 32'h40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
